pll_reset_ctrl: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 18 +
 rtl/sync_2ff.sv | 17 +
 rtl/pll_reset_ctrl.sv | 142 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared state encoding and widths for the PLL reset controller.
package pll_rst_pkg;

    localparam int RETRY_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_RESET_PLL = 2'd0;
    localparam state_t S_WAIT_LOCK = 2'd1;
    localparam state_t S_STABLE    = 2'd2;
    localparam state_t S_RUN       = 2'd3;

    // States during which the PLL is trying to acquire lock.
    function automatic logic in_acq(input state_t s);
        return (s == S_WAIT_LOCK) || (s == S_STABLE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for single-bit CDC into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: synchronizer flops carry no reset; they flush within two cycles
    // and a reset would only add a path from the reset net into the CDC stage.
    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL power-up and lock supervision: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional acquisition timeout with retry counting is enabled by `define PLLRST_TIMEOUT_EN.
module pll_reset_ctrl
    import pll_rst_pkg::*;
#(
    parameter int RST_PULSE   = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int TIMEOUT     = 1000000,
    parameter int CNT_W       = 20
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               soft_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt
);

    if (RST_PULSE < 2 || LOCK_STABLE < 1 || TIMEOUT < 1 ||
        longint'(RST_PULSE)   > (longint'(1) << CNT_W) - 1 ||
        longint'(LOCK_STABLE) > (longint'(1) << CNT_W) - 1 ||
        longint'(TIMEOUT)     > (longint'(1) << CNT_W) - 1) begin : g_bad_cfg
        $error("pll_reset_ctrl: parameter out of range or CNT_W too narrow");
    end

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);

    logic             locked_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_due;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .d   (locked),
        .q   (locked_s)
    );

`ifdef PLLRST_TIMEOUT_EN
    logic [CNT_W-1:0]   acq_cnt;
    logic [RETRY_W-1:0] retry_q;
    logic               retry_inc;

    assign timeout_due = (acq_cnt >= CNT_W'(TIMEOUT - 1));
    // Leaving acquisition for RESET_PLL without a soft request can only be a timeout.
    assign retry_inc   = in_acq(state) && (state_next == S_RESET_PLL) && !soft_req;
    assign retry_cnt   = retry_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            acq_cnt <= '0;
            retry_q <= '0;
        end else begin
            // Spans WAIT_LOCK and STABLE, so a STABLE lock drop keeps counting.
            if (in_acq(state) && in_acq(state_next)) begin
                acq_cnt <= acq_cnt + CNT_W'(1);
            end else begin
                acq_cnt <= '0;
            end
            if (retry_inc && retry_q != '1) begin
                retry_q <= retry_q + RETRY_W'(1);
            end
        end
    end
`else
    assign timeout_due = 1'b0;
    assign retry_cnt   = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        if (soft_req && state != S_RESET_PLL) begin
            state_next = S_RESET_PLL;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == PULSE_LAST) begin
                        state_next = S_WAIT_LOCK;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (timeout_due) begin
                        state_next = S_RESET_PLL;
                    end else if (locked_s) begin
                        state_next = S_STABLE;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_next = S_WAIT_LOCK;
                    end else if (timeout_due) begin
                        state_next = S_RESET_PLL;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = S_RUN;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (!locked_s) begin
                        state_next = S_RESET_PLL;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            // Outputs decode the next state so they switch with the state register.
            pll_rst <= (state_next == S_RESET_PLL);
            sys_rst <= (state_next != S_RUN);
            ready   <= (state_next == S_RUN);
            if (state == S_RUN && state_next == S_RESET_PLL && !soft_req) begin
                lock_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with RST_PULSE=4, LOCK_STABLE=8, TIMEOUT=40.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       soft_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pll_reset_ctrl #(
        .RST_PULSE   (4),
        .LOCK_STABLE (8),
        .TIMEOUT     (40),
        .CNT_W       (20)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .soft_req  (soft_req),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic locked;
        logic exp_pll_rst;
        logic exp_sys_rst;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic e_pll, input logic e_sys,
                              input logic e_lost);
        check({name, ".pll_rst"},   int'(pll_rst),   int'(e_pll));
        check({name, ".sys_rst"},   int'(sys_rst),   int'(e_sys));
        check({name, ".ready"},     int'(ready),     int'(!e_sys));
        check({name, ".lock_lost"}, int'(lock_lost), int'(e_lost));
    endtask

    // Inputs set and outputs sampled on the falling edge.
    task automatic step();
        @(posedge refclk);
        @(negedge refclk);
        cyc++;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        int t, u, r, s;
        logic saw_pll;

        rst      = 1'b1;
        locked   = 1'b0;
        soft_req = 1'b0;
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check_outs("reset", 1'b1, 1'b1, 1'b0);
        check("reset.retry_cnt", int'(retry_cnt), 0);

        // Power-up: locked rises at cycle 10, RUN at 21.
        for (int i = 0; i < 24; i++) begin
            vecs[i].locked      = (i >= 10);
            vecs[i].exp_pll_rst = (i < 4);
            vecs[i].exp_sys_rst = (i < 21);
        end
        rst = 1'b0;
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            locked = vecs[i].locked;
            check_outs($sformatf("powerup[%0d]", i), vecs[i].exp_pll_rst,
                       vecs[i].exp_sys_rst, 1'b0);
            step();
        end

        // Lock loss in RUN.
        t = cyc;
        locked = 1'b0;
        wait_cyc(t + 2);
        check_outs("loss_t2", 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 3);
        check_outs("loss_t3", 1'b1, 1'b1, 1'b1);
        wait_cyc(t + 6);
        check_outs("loss_t6", 1'b1, 1'b1, 1'b1);
        wait_cyc(t + 7);
        check_outs("loss_t7", 1'b0, 1'b1, 1'b1);

        // Relock with a 3-cycle dropout in STABLE: no PLL reset, count restarts.
        u = t + 8;
        r = u + 8;
        wait_cyc(u);
        saw_pll = 1'b0;
        while (cyc <= r + 11) begin
            if (cyc == u)     locked = 1'b1;
            if (cyc == u + 5) locked = 1'b0;
            if (cyc == r)     locked = 1'b1;
            if (pll_rst) saw_pll = 1'b1;
            if (cyc == r + 10) check("dropout.sys_rst_before", int'(sys_rst), 1);
            if (cyc == r + 11) check_outs("dropout.run", 1'b0, 1'b0, 1'b1);
            step();
        end
        check("dropout.no_pll_pulse", int'(saw_pll), 0);

        // soft_req in RUN; a second request during RESET_PLL is ignored.
        s = cyc;
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        check_outs("soft.t1", 1'b1, 1'b1, 1'b1);
        check("soft.retry_cnt", int'(retry_cnt), 0);
        wait_cyc(s + 2);
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        wait_cyc(s + 4);
        check("soft.pll_last", int'(pll_rst), 1);
        wait_cyc(s + 5);
        check("soft.pll_end", int'(pll_rst), 0);
        wait_cyc(s + 13);
        check("soft.sys_before", int'(sys_rst), 1);
        wait_cyc(s + 14);
        check_outs("soft.run", 1'b0, 1'b0, 1'b1);

        // rst mid-RUN clears everything, including the sticky flag.
        rst = 1'b1;
        step();
        check_outs("midrst", 1'b1, 1'b1, 1'b0);
        check("midrst.retry_cnt", int'(retry_cnt), 0);
        rst = 1'b0;
        cyc = 0;
        wait_cyc(3);
        check("midrst.pll3", int'(pll_rst), 1);
        wait_cyc(4);
        check("midrst.pll4", int'(pll_rst), 0);
        wait_cyc(12);
        check("midrst.sys12", int'(sys_rst), 1);
        wait_cyc(13);
        check_outs("midrst.run", 1'b0, 1'b0, 1'b0);

        // Locked held low from a fresh reset.
        rst    = 1'b1;
        locked = 1'b0;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
`ifdef PLLRST_TIMEOUT_EN
        wait_cyc(43);
        check("to.pll43", int'(pll_rst), 0);
        check("to.retry43", int'(retry_cnt), 0);
        wait_cyc(44);
        check("to.pll44", int'(pll_rst), 1);
        check("to.retry44", int'(retry_cnt), 1);
        wait_cyc(48);
        check("to.pll48", int'(pll_rst), 0);
        wait_cyc(88);
        check("to.pll88", int'(pll_rst), 1);
        check("to.retry88", int'(retry_cnt), 2);
        wait_cyc(100);
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        check("to.soft_pll", int'(pll_rst), 1);
        check("to.soft_retry", int'(retry_cnt), 2);
        wait_cyc(101 + 44 * 262);
        check("to.saturate", int'(retry_cnt), 255);
        check("to.sys_rst", int'(sys_rst), 1);
`else
        wait_cyc(4);
        saw_pll = 1'b0;
        while (cyc < 200) begin
            if (pll_rst) saw_pll = 1'b1;
            step();
        end
        check("noto.no_retry_pulse", int'(saw_pll), 0);
        check("noto.retry_cnt", int'(retry_cnt), 0);
        check("noto.sys_rst", int'(sys_rst), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
